// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: ALU op codes,
// conditional-branch funct3 codes and the controller state encoding.
package alu_issue_ctrl_pkg;

    // ALU operation codes (aludefs)
    localparam logic [4:0] ALUOP_ADD  = 5'd0;
    localparam logic [4:0] ALUOP_SUB  = 5'd1;
    localparam logic [4:0] ALUOP_SLL  = 5'd2;
    localparam logic [4:0] ALUOP_SLT  = 5'd3;
    localparam logic [4:0] ALUOP_SLTU = 5'd4;
    localparam logic [4:0] ALUOP_XOR  = 5'd5;
    localparam logic [4:0] ALUOP_SRL  = 5'd6;
    localparam logic [4:0] ALUOP_SRA  = 5'd7;
    localparam logic [4:0] ALUOP_OR   = 5'd8;
    localparam logic [4:0] ALUOP_AND  = 5'd9;

    // Conditional branch funct3 codes
    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one execute request, drives the ALU until
// it stops reporting busy (or the edge budget runs out), resolves the branch
// condition and presents a single writeback beat.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CNT_W   = 6
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_req_valid,
    output logic        O_req_ready,
    input  logic [4:0]  I_req_op,
    input  logic [31:0] I_req_s1,
    input  logic [31:0] I_req_s2,
    input  logic [4:0]  I_req_rd,
    input  logic        I_req_isbr,
    input  logic [2:0]  I_req_brf3,
    output logic        O_alu_en,
    output logic [4:0]  O_alu_op,
    output logic [31:0] O_alu_s1,
    output logic [31:0] O_alu_s2,
    input  logic        I_alu_busy,
    input  logic [31:0] I_alu_data,
    input  logic        I_alu_lt,
    input  logic        I_alu_ltu,
    input  logic        I_alu_eq,
    output logic        O_wb_valid,
    input  logic        I_wb_ready,
    output logic [31:0] O_wb_data,
    output logic [4:0]  O_wb_rd,
    output logic        O_wb_taken,
    output logic        O_wb_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              issued_q, issued_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        op_q, op_d;
    logic [31:0]       s1_q, s1_d;
    logic [31:0]       s2_q, s2_d;
    logic [4:0]        rd_q, rd_d;
    logic              isbr_q, isbr_d;
    logic [2:0]        brf3_q, brf3_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              wb_taken_q, wb_taken_d;
    logic              wb_err_q, wb_err_d;

    logic accept, alu_en, timeout_hit, capture;

    function automatic logic br_cond(input logic [2:0] f3, input logic lt,
                                     input logic ltu, input logic eq);
        logic r;
        r = 1'b0;
        case (f3)
            BR_EQ:   r = eq;
            BR_NE:   r = !eq;
            BR_LT:   r = lt;
            BR_GE:   r = !lt;
            BR_LTU:  r = ltu;
            BR_GEU:  r = !ltu;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Handshake and ALU sequencing qualifiers
    always_comb begin
        accept      = I_req_valid && (state_q == ST_IDLE);
        alu_en      = (state_q == ST_EXEC) && (!issued_q || I_alu_busy);
        timeout_hit = alu_en && (cnt_q == CNT_LAST);
        capture     = (state_q == ST_EXEC) && issued_q && !I_alu_busy;
    end

    // State register
    always_ff @(posedge I_clk) begin
        if (I_reset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: if (timeout_hit || capture) state_d = ST_WB;
            ST_WB:   if (I_wb_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, edge counter and writeback capture
    always_comb begin
        issued_d   = issued_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        rd_d       = rd_q;
        isbr_d     = isbr_q;
        brf3_d     = brf3_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_taken_d = wb_taken_q;
        wb_err_d   = wb_err_q;
        if (accept) begin
            op_d     = I_req_op;
            s1_d     = I_req_s1;
            s2_d     = I_req_s2;
            rd_d     = I_req_rd;
            isbr_d   = I_req_isbr;
            brf3_d   = I_req_brf3;
            issued_d = 1'b0;
            cnt_d    = '0;
        end
        if (alu_en) begin
            issued_d = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
        end
        // Timeout wins over a capture in the same cycle
        if (timeout_hit) begin
            wb_data_d  = '0;
            wb_err_d   = 1'b1;
            wb_taken_d = 1'b0;
            wb_rd_d    = isbr_q ? 5'd0 : rd_q;
        end else if (capture) begin
            wb_data_d  = I_alu_data;
            wb_err_d   = 1'b0;
            wb_taken_d = isbr_q & br_cond(brf3_q, I_alu_lt, I_alu_ltu, I_alu_eq);
            wb_rd_d    = isbr_q ? 5'd0 : rd_q;
        end
    end

    // Datapath registers
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            issued_q   <= 1'b0;
            cnt_q      <= '0;
            op_q       <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            rd_q       <= '0;
            isbr_q     <= 1'b0;
            brf3_q     <= '0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_taken_q <= 1'b0;
            wb_err_q   <= 1'b0;
        end else begin
            issued_q   <= issued_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            rd_q       <= rd_d;
            isbr_q     <= isbr_d;
            brf3_q     <= brf3_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_taken_q <= wb_taken_d;
            wb_err_q   <= wb_err_d;
        end
    end

    // Output decode
    always_comb begin
        O_req_ready = (state_q == ST_IDLE);
        O_alu_en    = alu_en;
        O_alu_op    = op_q;
        O_alu_s1    = s1_q;
        O_alu_s2    = s2_q;
        O_wb_valid  = (state_q == ST_WB);
        O_wb_data   = wb_data_q;
        O_wb_rd     = wb_rd_q;
        O_wb_taken  = wb_taken_q;
        O_wb_err    = wb_err_q;
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural multi-cycle ALU:
// shifts by n stay busy for n+1 further enabled edges after issue.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    logic        I_clk = 1'b0;
    logic        I_reset;
    logic        I_req_valid;
    logic        O_req_ready;
    logic [4:0]  I_req_op;
    logic [31:0] I_req_s1, I_req_s2;
    logic [4:0]  I_req_rd;
    logic        I_req_isbr;
    logic [2:0]  I_req_brf3;
    logic        O_alu_en;
    logic [4:0]  O_alu_op;
    logic [31:0] O_alu_s1, O_alu_s2;
    logic        I_alu_busy;
    logic [31:0] I_alu_data;
    logic        I_alu_lt, I_alu_ltu, I_alu_eq;
    logic        O_wb_valid;
    logic        I_wb_ready;
    logic [31:0] O_wb_data;
    logic [4:0]  O_wb_rd;
    logic        O_wb_taken, O_wb_err;

    int n_checks = 0;
    int n_fail   = 0;
    int en_total = 0;

    // ALU model state
    logic       m_busy;
    logic [5:0] m_cnt;
    logic       stub_busy = 1'b0;

    always #5 I_clk = ~I_clk;

    alu_issue_ctrl #(.TIMEOUT(40), .CNT_W(6)) dut (
        .I_clk(I_clk), .I_reset(I_reset),
        .I_req_valid(I_req_valid), .O_req_ready(O_req_ready),
        .I_req_op(I_req_op), .I_req_s1(I_req_s1), .I_req_s2(I_req_s2),
        .I_req_rd(I_req_rd), .I_req_isbr(I_req_isbr), .I_req_brf3(I_req_brf3),
        .O_alu_en(O_alu_en), .O_alu_op(O_alu_op), .O_alu_s1(O_alu_s1), .O_alu_s2(O_alu_s2),
        .I_alu_busy(I_alu_busy), .I_alu_data(I_alu_data),
        .I_alu_lt(I_alu_lt), .I_alu_ltu(I_alu_ltu), .I_alu_eq(I_alu_eq),
        .O_wb_valid(O_wb_valid), .I_wb_ready(I_wb_ready),
        .O_wb_data(O_wb_data), .O_wb_rd(O_wb_rd),
        .O_wb_taken(O_wb_taken), .O_wb_err(O_wb_err)
    );

    assign I_alu_busy = stub_busy | m_busy;

    // Behavioural ALU sharing the controller reset
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            m_busy <= 1'b0; m_cnt <= '0; I_alu_data <= '0;
            I_alu_lt <= 1'b0; I_alu_ltu <= 1'b0; I_alu_eq <= 1'b0;
        end else if (O_alu_en) begin
            if (!m_busy) begin
                case (O_alu_op)
                    ALUOP_ADD: I_alu_data <= O_alu_s1 + O_alu_s2;
                    ALUOP_SUB: I_alu_data <= O_alu_s1 - O_alu_s2;
                    ALUOP_SLL: I_alu_data <= O_alu_s1 << O_alu_s2[4:0];
                    ALUOP_SRL: I_alu_data <= O_alu_s1 >> O_alu_s2[4:0];
                    ALUOP_SRA: I_alu_data <= $signed(O_alu_s1) >>> O_alu_s2[4:0];
                    default:   I_alu_data <= O_alu_s1 & O_alu_s2;
                endcase
                I_alu_lt  <= $signed(O_alu_s1) < $signed(O_alu_s2);
                I_alu_ltu <= O_alu_s1 < O_alu_s2;
                I_alu_eq  <= O_alu_s1 == O_alu_s2;
                if (O_alu_op == ALUOP_SLL || O_alu_op == ALUOP_SRL || O_alu_op == ALUOP_SRA) begin
                    m_busy <= 1'b1;
                    m_cnt  <= {1'b0, O_alu_s2[4:0]} + 6'd1;
                end
            end else begin
                m_cnt <= m_cnt - 6'd1;
                if (m_cnt == 6'd1) m_busy <= 1'b0;
            end
        end
    end

    // Running count of enabled ALU edges
    always @(posedge I_clk) if (O_alu_en) en_total++;

    task automatic step();
        @(posedge I_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single cycle; returns the edge-count base
    task automatic issue(input logic [4:0] op, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [4:0] rd, input logic isbr, input logic [2:0] f3,
                         output int base);
        check("req_ready_before_issue", 32'(O_req_ready), 32'd1);
        I_req_valid = 1'b1; I_req_op = op; I_req_s1 = s1; I_req_s2 = s2;
        I_req_rd = rd; I_req_isbr = isbr; I_req_brf3 = f3;
        base = en_total;
        step();
        I_req_valid = 1'b0;
    endtask

    // Cycles from accept edge until O_wb_valid, bounded
    task automatic wait_wb(output int lat);
        lat = 0;
        while (!O_wb_valid && lat < 200) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int base, lat, seen_wb;
        I_reset = 1'b1; I_req_valid = 1'b0; I_req_op = '0; I_req_s1 = '0; I_req_s2 = '0;
        I_req_rd = '0; I_req_isbr = 1'b0; I_req_brf3 = '0; I_wb_ready = 1'b1;
        repeat (3) step();
        check("rst_req_ready", 32'(O_req_ready), 32'd1);
        check("rst_alu_en",    32'(O_alu_en),    32'd0);
        check("rst_wb_valid",  32'(O_wb_valid),  32'd0);
        check("rst_wb_data",   O_wb_data,        32'd0);
        check("rst_wb_rd",     32'(O_wb_rd),     32'd0);
        check("rst_wb_taken",  32'(O_wb_taken),  32'd0);
        check("rst_wb_err",    32'(O_wb_err),    32'd0);
        check("rst_alu_s1",    O_alu_s1,         32'd0);
        I_reset = 1'b0;
        step();

        // ADD 5+7 -> 12, single enabled edge, 2-cycle latency
        issue(ALUOP_ADD, 32'd5, 32'd7, 5'd3, 1'b0, 3'b000, base);
        check("add_ready_low_exec", 32'(O_req_ready), 32'd0);
        wait_wb(lat);
        check("add_latency", 32'(lat), 32'd2);
        check("add_en_edges", 32'(en_total - base), 32'd1);
        check("add_data", O_wb_data, 32'd12);
        check("add_rd", 32'(O_wb_rd), 32'd3);
        check("add_err", 32'(O_wb_err), 32'd0);
        check("add_taken", 32'(O_wb_taken), 32'd0);
        check("add_ready_low_wb", 32'(O_req_ready), 32'd0);
        step();
        check("add_wb_done", 32'(O_wb_valid), 32'd0);

        // SLL 1<<4 -> 0x10, 6 enabled edges, 7-cycle latency
        issue(ALUOP_SLL, 32'd1, 32'd4, 5'd7, 1'b0, 3'b000, base);
        wait_wb(lat);
        check("sll_latency", 32'(lat), 32'd7);
        check("sll_en_edges", 32'(en_total - base), 32'd6);
        check("sll_data", O_wb_data, 32'h10);
        check("sll_rd", 32'(O_wb_rd), 32'd7);
        step();

        // BLT -1 < 1 signed: taken, rd forced to 0
        issue(ALUOP_SUB, 32'hFFFF_FFFF, 32'd1, 5'd9, 1'b1, BR_LT, base);
        wait_wb(lat);
        check("blt_latency", 32'(lat), 32'd2);
        check("blt_taken", 32'(O_wb_taken), 32'd1);
        check("blt_rd", 32'(O_wb_rd), 32'd0);
        check("blt_data", O_wb_data, 32'hFFFF_FFFE);
        step();

        // BLTU 0xFFFFFFFF < 1 unsigned: not taken
        issue(ALUOP_SUB, 32'hFFFF_FFFF, 32'd1, 5'd9, 1'b1, BR_LTU, base);
        wait_wb(lat);
        check("bltu_taken", 32'(O_wb_taken), 32'd0);
        check("bltu_rd", 32'(O_wb_rd), 32'd0);
        step();

        // funct3 010 never taken even with equal operands
        issue(ALUOP_SUB, 32'd8, 32'd8, 5'd2, 1'b1, 3'b010, base);
        wait_wb(lat);
        check("br010_taken", 32'(O_wb_taken), 32'd0);
        step();

        // BEQ with consumer stalled 4 cycles: beat held stable
        I_wb_ready = 1'b0;
        issue(ALUOP_SUB, 32'h1234, 32'h1234, 5'd4, 1'b1, BR_EQ, base);
        wait_wb(lat);
        for (int i = 0; i < 4; i++) begin
            check("beq_hold_valid", 32'(O_wb_valid), 32'd1);
            check("beq_hold_data", O_wb_data, 32'd0);
            check("beq_hold_taken", 32'(O_wb_taken), 32'd1);
            check("beq_hold_ready", 32'(O_req_ready), 32'd0);
            check("beq_hold_alu_en", 32'(O_alu_en), 32'd0);
            step();
        end
        I_wb_ready = 1'b1;
        step();
        check("beq_released_valid", 32'(O_wb_valid), 32'd0);
        check("beq_released_ready", 32'(O_req_ready), 32'd1);

        // ALU stuck busy: abort after exactly 40 enabled edges
        stub_busy = 1'b1;
        issue(ALUOP_ADD, 32'd3, 32'd4, 5'd5, 1'b0, 3'b000, base);
        wait_wb(lat);
        check("tmo_latency", 32'(lat), 32'd40);
        check("tmo_en_edges", 32'(en_total - base), 32'd40);
        check("tmo_err", 32'(O_wb_err), 32'd1);
        check("tmo_data", O_wb_data, 32'd0);
        check("tmo_taken", 32'(O_wb_taken), 32'd0);
        check("tmo_alu_en_wb", 32'(O_alu_en), 32'd0);
        stub_busy = 1'b0;
        step();

        // Reset during a 20-bit shift: no beat, then normal operation
        issue(ALUOP_SLL, 32'd1, 32'd20, 5'd6, 1'b0, 3'b000, base);
        repeat (4) step();
        check("rst_mid_alu_en_before", 32'(O_alu_en), 32'd1);
        I_reset = 1'b1;
        step();
        I_reset = 1'b0;
        check("rst_mid_alu_en", 32'(O_alu_en), 32'd0);
        check("rst_mid_ready", 32'(O_req_ready), 32'd1);
        check("rst_mid_wb_valid", 32'(O_wb_valid), 32'd0);
        seen_wb = 0;
        for (int i = 0; i < 30; i++) begin
            if (O_wb_valid || O_alu_en) seen_wb = 1;
            step();
        end
        check("rst_mid_no_beat", 32'(seen_wb), 32'd0);
        issue(ALUOP_ADD, 32'd2, 32'd2, 5'd1, 1'b0, 3'b000, base);
        wait_wb(lat);
        check("post_rst_latency", 32'(lat), 32'd2);
        check("post_rst_data", O_wb_data, 32'd4);
        check("post_rst_err", 32'(O_wb_err), 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
